ysyx_icache: RTL and testbench

Direct-mapped, read-only L1 instruction cache between the IFU fetch port and the bus arbiter's `ifu_araddr/ifu_arvalid/ifu_rdata_o/ifu_rvalid_o` port.

- Hits return data one cycle after lookup, with no bus activity.
- Misses refill the whole line as a sequence of single-beat reads through the arbiter, then return the requested word.
- `flush` (fence.i) invalidates every line.

---
 rtl/ysyx_icache_if.sv | 25 ++
 rtl/ysyx_icache.sv | 140 ++++++++++++++
 tb/tb_ysyx_icache.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_icache_if.sv
// Fetch-side (IFU) and refill-side (arbiter) signals of the instruction cache.
// The cache takes the slave view; the IFU plus arbiter environment takes the master view.
interface ysyx_icache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_req;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rvalid;
  logic [ADDR_W-1:0] bus_araddr;
  logic              bus_arvalid;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rvalid;

  modport slave (
    input  ifu_addr, ifu_req, bus_rdata, bus_rvalid,
    output ifu_rdata, ifu_rvalid, bus_araddr, bus_arvalid
  );

  modport master (
    output ifu_addr, ifu_req, bus_rdata, bus_rvalid,
    input  ifu_rdata, ifu_rvalid, bus_araddr, bus_arvalid
  );
endinterface

// File: rtl/ysyx_icache.sv
// Direct-mapped read-only L1 instruction cache; misses refill the whole line
// word by word (word 0 first) through the bus arbiter.
module ysyx_icache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 16,
  parameter int WORDS  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  ysyx_icache_if.slave link,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - IW - OW - 2;
  localparam logic [OW-1:0] LAST = OW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

  state_t            state_reg;
  logic [SETS-1:0]   valid_reg;
  logic [TW-1:0]     tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS*WORDS];
  logic [TW-1:0]     req_tag_reg;
  logic [IW-1:0]     req_idx_reg;
  logic [OW-1:0]     req_off_reg;
  logic [OW-1:0]     cnt_reg;
  logic              kill_reg;

  logic [TW-1:0]   look_tag;
  logic [IW-1:0]   look_idx;
  logic [OW-1:0]   look_off;
  logic [OW-1:0]   cnt_inc;
  logic            look_hit;
  logic            beat;
  logic            last_beat;
  logic            install;
  logic [SETS-1:0] set_sel;
  logic            unused_byte_sel;

  assign look_tag        = link.ifu_addr[ADDR_W-1 -: TW];
  assign look_idx        = link.ifu_addr[2+OW +: IW];
  assign look_off        = link.ifu_addr[2 +: OW];
  assign unused_byte_sel = ^link.ifu_addr[1:0];
  assign cnt_inc         = cnt_reg + OW'(1);

  // A flush in the lookup cycle wipes the line at this same edge, so it must miss.
  assign look_hit  = valid_reg[look_idx] && (tag_mem[look_idx] == look_tag) && !flush;
  assign beat      = (state_reg == REFILL) && link.bus_rvalid;
  assign last_beat = beat && (cnt_reg == LAST);
  assign install   = last_beat && !kill_reg && !flush;

  always_ff @(posedge clk) begin
    if (beat)
      data_mem[{req_idx_reg, cnt_reg}] <= link.bus_rdata;
    if (install)
      tag_mem[req_idx_reg] <= req_tag_reg;
  end

  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_set_sel
      assign set_sel[gi] = (req_idx_reg == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush)
      valid_reg <= '0;
    else if (install)
      valid_reg <= valid_reg | set_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      req_tag_reg      <= '0;
      req_idx_reg      <= '0;
      req_off_reg      <= '0;
      cnt_reg          <= '0;
      kill_reg         <= 1'b0;
      link.ifu_rvalid  <= 1'b0;
      link.ifu_rdata   <= '0;
      link.bus_arvalid <= 1'b0;
      link.bus_araddr  <= '0;
      hit_cnt          <= '0;
      miss_cnt         <= '0;
    end else begin
      link.ifu_rvalid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (link.ifu_req) begin
            if (look_hit) begin
              link.ifu_rdata  <= data_mem[{look_idx, look_off}];
              link.ifu_rvalid <= 1'b1;
              hit_cnt         <= hit_cnt + 32'd1;
              state_reg       <= RESP;
            end else begin
              req_tag_reg      <= look_tag;
              req_idx_reg      <= look_idx;
              req_off_reg      <= look_off;
              cnt_reg          <= '0;
              kill_reg         <= 1'b0;
              miss_cnt         <= miss_cnt + 32'd1;
              link.bus_arvalid <= 1'b1;
              link.bus_araddr  <= {look_tag, look_idx, {OW{1'b0}}, 2'b00};
              state_reg        <= REFILL;
            end
          end
        end
        REFILL: begin
          if (flush)
            kill_reg <= 1'b1;
          if (link.bus_rvalid) begin
            cnt_reg <= cnt_inc;
            if (cnt_reg == LAST) begin
              // The last word is still on the bus; earlier words are already in the array.
              link.ifu_rdata   <= (req_off_reg == LAST) ? link.bus_rdata
                                                        : data_mem[{req_idx_reg, req_off_reg}];
              // A redirected fetch (request dropped) gets no response pulse.
              link.ifu_rvalid  <= link.ifu_req;
              link.bus_arvalid <= 1'b0;
              state_reg        <= RESP;
            end else begin
              link.bus_araddr <= {req_tag_reg, req_idx_reg, cnt_inc, 2'b00};
            end
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_icache.sv
// Scoreboard bench for ysyx_icache: a line-per-set model predicts hits and
// misses, an arbiter model answers refills, and a monitor checks every response.
module tb_ysyx_icache;
  localparam int SETS  = 16;
  localparam int WORDS = 4;
  localparam int OW    = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic        arb_rv;
  logic        late_rv;
  logic [31:0] arb_rdata;

  ysyx_icache_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  assign ifc.bus_rvalid = arb_rv | late_rv;
  assign ifc.bus_rdata  = arb_rdata;

  ysyx_icache #(.ADDR_W(32), .DATA_W(32), .SETS(SETS), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .link     (ifc),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  logic [31:0] beat_q[$];
  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  int          beat_no = 0;
  int          last_beat_cyc = 0;
  int          lat_min = 1;
  int          lat_max = 3;
  logic        prev_rv = 1'b0;
  bit          model_vld [SETS];
  int unsigned model_line [SETS];
  int          exp_hit, exp_miss, n_look;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + ((a - 32'h8000_0000) >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) model_vld[s] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".ifu_rvalid"},  32'(ifc.ifu_rvalid), 0);
    check({tag, ".ifu_rdata"},   ifc.ifu_rdata, 0);
    check({tag, ".bus_arvalid"}, 32'(ifc.bus_arvalid), 0);
    check({tag, ".bus_araddr"},  ifc.bus_araddr, 0);
    check({tag, ".hit_cnt"},     hit_cnt, 0);
    check({tag, ".miss_cnt"},    miss_cnt, 0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".hit_cnt"},  hit_cnt, 32'(exp_hit));
    check({tag, ".miss_cnt"}, miss_cnt, 32'(exp_miss));
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Arbiter model: 0..N idle cycles per beat, data from the memory model.
  initial begin
    int wait_left;
    arb_rv    = 1'b0;
    arb_rdata = '0;
    wait_left = -1;
    forever begin
      @(posedge clk); #1;
      arb_rv = 1'b0;
      if (ifc.bus_arvalid && !rst) begin
        if (wait_left < 0) wait_left = int'($urandom_range(lat_max, lat_min));
        if (wait_left == 0) begin
          arb_rv        = 1'b1;
          arb_rdata     = mem_word(ifc.bus_araddr);
          beat_no       = beat_no + 1;
          last_beat_cyc = cycle;
          wait_left     = -1;
        end else begin
          wait_left--;
        end
      end else begin
        wait_left = -1;
      end
    end
  end

  // Monitor: pops expected beats and responses whenever the DUT presents them.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] ea;
    if (rst) begin
      sb_q.delete();
      beat_q.delete();
      prev_rv <= 1'b0;
    end else begin
      if (beat_q.size() == 0 && !arb_rv)
        check("arvalid_idle", 32'(ifc.bus_arvalid), 0);
      if (arb_rv) begin
        if (beat_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexp: got beat at %h expected none", ifc.bus_araddr);
        end else begin
          ea = beat_q.pop_front();
          check("beat_addr", ifc.bus_araddr, ea);
        end
      end
      if (ifc.ifu_rvalid) begin
        check("rvalid_gap", 32'(prev_rv), 0);
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rvalid_unexp: got data %h expected no response", ifc.ifu_rdata);
        end else begin
          e = sb_q.pop_front();
          $display("fetch addr=%h data=%h exp=%h", e.addr, ifc.ifu_rdata, e.data);
          check("rdata", ifc.ifu_rdata, e.data);
        end
      end
      prev_rv <= ifc.ifu_rvalid;
    end
  end

  // mode 0: normal, 1: flush on beat 2, 2: redirect after beat 1, 3: reset after beat 2
  task automatic fetch(input logic [31:0] a, input int mode);
    int unsigned line, set;
    bit          hit, got, done, kicked;
    int          cyc, start, rv_cyc, nb;
    line = a >> (2 + OW);
    set  = line % SETS;
    hit  = model_vld[set] && (model_line[set] == line);
    n_look++;
    if (hit) exp_hit++; else exp_miss++;
    if (!hit)
      for (int k = 0; k < WORDS; k++) beat_q.push_back(32'((line << (2 + OW)) + 4 * k));
    if (mode <= 1) sb_q.push_back('{a, mem_word(a)});
    @(posedge clk); #1;
    start = beat_no;
    ifc.ifu_addr = a;
    ifc.ifu_req  = 1'b1;
    cyc = 0; got = 0; done = 0; kicked = 0; rv_cyc = 0; nb = 0;
    while (cyc < 2000 && !got && !done) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      nb = beat_no - start;
      if (ifc.ifu_rvalid) begin
        got = 1; rv_cyc = cycle;
      end else if (mode == 1 && nb == 2 && arb_rv && !kicked) begin
        flush = 1'b1; kicked = 1;
      end else if (mode == 2 && nb == 1 && ifc.ifu_req && !arb_rv) begin
        ifc.ifu_req = 1'b0;
      end else if (mode == 2 && nb == WORDS && !arb_rv && !ifc.bus_arvalid) begin
        done = 1;
      end else if (mode == 3 && nb == 2 && !arb_rv) begin
        rst = 1'b1; ifc.ifu_req = 1'b0; done = 1;
      end
    end
    if (mode <= 1) begin
      check("resp_seen", 32'(got), 1);
      if (hit) begin
        check("hit_lat", 32'(cyc), 2);
        check("hit_beats", 32'(nb), 0);
      end else begin
        check("miss_lat", 32'(rv_cyc), 32'(last_beat_cyc + 1));
        check("miss_beats", 32'(nb), 32'(WORDS));
      end
      if (mode == 1) check("flush_on_beat2", 32'(kicked), 1);
    end else if (mode == 2) begin
      $display("redirect addr=%h beats=%0d", a, nb);
      check("redirect_beats", 32'(nb), 32'(WORDS));
    end else begin
      $display("reset mid-refill addr=%h beats=%0d", a, nb);
      check("reset_point", 32'(done), 1);
    end
    @(posedge clk); #1;
    ifc.ifu_req = 1'b0;
    flush = 1'b0;
    if (mode == 2) repeat (2) @(posedge clk);
    if (mode == 3) begin
      @(negedge clk);
      check_idle_outputs("after_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      late_rv = 1'b1;
      @(posedge clk); #1;
      late_rv = 1'b0;
      repeat (2) @(negedge clk);
      check("late_rv.bus_arvalid", 32'(ifc.bus_arvalid), 0);
      check("late_rv.ifu_rvalid", 32'(ifc.ifu_rvalid), 0);
      check("late_rv.hit_cnt", hit_cnt, 0);
      check("late_rv.miss_cnt", miss_cnt, 0);
      model_clear();
      exp_hit = 0; exp_miss = 0; n_look = 0;
    end else if (!hit) begin
      if (mode == 1) begin
        model_clear();
      end else begin
        model_vld[set]  = 1'b1;
        model_line[set] = line;
      end
    end
  endtask

  initial begin
    flush = 1'b0;
    late_rv = 1'b0;
    ifc.ifu_addr = '0;
    ifc.ifu_req = 1'b0;
    exp_hit = 0; exp_miss = 0; n_look = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    lat_min = 1; lat_max = 3;
    fetch(32'h8000_0008, 0);
    check_counters("cold_miss");
    fetch(32'h8000_000C, 0);
    check_counters("first_hit");

    do_flush();
    fetch(32'h8000_0000, 0);
    fetch(32'h8000_0100, 0);
    fetch(32'h8000_0000, 0);
    check_counters("conflict");

    fetch(32'h8000_0000, 0);
    do_flush();
    fetch(32'h8000_0000, 0);
    do_flush();
    fetch(32'h8000_0004, 1);
    fetch(32'h8000_0004, 0);
    check_counters("flush");

    lat_min = 2; lat_max = 4;
    fetch(32'h8000_0040, 2);
    fetch(32'h8000_0048, 0);
    check_counters("redirect");

    fetch(32'h8000_0080, 3);
    fetch(32'h8000_0080, 0);
    check_counters("reset_refill");

    lat_min = 0; lat_max = 20;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 19) == 0) do_flush();
      fetch(32'h8000_0000 + ($urandom_range(0, 255) << 2), 0);
    end
    repeat (2) @(negedge clk);
    check_counters("random");
    check("lookups", hit_cnt + miss_cnt, 32'(n_look));
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
